// File: rtl/imm_ext_issue.sv
// ID->EX immediate issue stage: opcode decode, immediate extension and a 2-entry skid buffer.
// Optional feature macro LUI_UPPER_EN: when defined, LUI issues pre-shifted in mode UPPER.
module imm_ext_issue #(
   parameter logic [31:0] NONE_IMM = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        flush,
   input  logic        id_valid,
   output logic        id_ready,
   input  logic [31:0] id_instr,
   input  logic [31:0] id_pc,
   output logic        ex_valid,
   input  logic        ex_ready,
   output logic [31:0] ex_imm,
   output logic [1:0]  ex_mode,
   output logic [31:0] ex_pc
);

   localparam logic [1:0] MODE_NONE  = 2'b00;
   localparam logic [1:0] MODE_SIGN  = 2'b01;
   localparam logic [1:0] MODE_ZERO  = 2'b10;
   localparam logic [1:0] MODE_UPPER = 2'b11;

   logic [5:0]  opcode;
   logic [15:0] imm16;
   logic [31:0] dec_imm;
   logic [1:0]  dec_mode;
   logic        accept;

   logic        out_valid_q, out_valid_d;
   logic [31:0] out_imm_q, out_imm_d;
   logic [1:0]  out_mode_q, out_mode_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic        skid_valid_q, skid_valid_d;
   logic [31:0] skid_imm_q, skid_imm_d;
   logic [1:0]  skid_mode_q, skid_mode_d;
   logic [31:0] skid_pc_q, skid_pc_d;

   // Register fields [25:16] carry no immediate information for this stage.
   logic unused_rs_rt;
   assign unused_rs_rt = ^id_instr[25:16];

   assign opcode = id_instr[31:26];
   assign imm16  = id_instr[15:0];

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      dec_imm  = NONE_IMM;
      dec_mode = MODE_NONE;
      casez (opcode)
         6'b0010??, 6'b10????: begin
            dec_imm  = {{16{imm16[15]}}, imm16};
            dec_mode = MODE_SIGN;
         end
         6'b001100, 6'b001101, 6'b001110: begin
            dec_imm  = {16'h0000, imm16};
            dec_mode = MODE_ZERO;
         end
         6'b001111: begin
`ifdef LUI_UPPER_EN
            dec_imm  = {imm16, 16'h0000};
            dec_mode = MODE_UPPER;
`else
            dec_imm  = {16'h0000, imm16};
            dec_mode = MODE_ZERO;
`endif
         end
         6'b0001??, 6'b000001: begin
            dec_imm  = {{14{imm16[15]}}, imm16, 2'b00};
            dec_mode = MODE_SIGN;
         end
         default: ;
      endcase
   end

   // id_ready depends only on registered state, never on ex_ready.
   assign id_ready = ~skid_valid_q;
   assign accept   = id_valid & id_ready;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_imm_d    = out_imm_q;
      out_mode_d   = out_mode_q;
      out_pc_d     = out_pc_q;
      skid_valid_d = skid_valid_q;
      skid_imm_d   = skid_imm_q;
      skid_mode_d  = skid_mode_q;
      skid_pc_d    = skid_pc_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || ex_ready) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_imm_d    = skid_imm_q;
            out_mode_d   = skid_mode_q;
            out_pc_d     = skid_pc_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_valid_d = 1'b1;
            out_imm_d   = dec_imm;
            out_mode_d  = dec_mode;
            out_pc_d    = id_pc;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_imm_d   = dec_imm;
         skid_mode_d  = dec_mode;
         skid_pc_d    = id_pc;
      end
   end

   // NOTE: sequential state uses non-blocking assignments; data registers are
   // reset too because ex_imm/ex_mode/ex_pc must read zero out of reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_valid_q  <= 1'b0;
         out_imm_q    <= 32'h0;
         out_mode_q   <= MODE_NONE;
         out_pc_q     <= 32'h0;
         skid_valid_q <= 1'b0;
         skid_imm_q   <= 32'h0;
         skid_mode_q  <= MODE_NONE;
         skid_pc_q    <= 32'h0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_imm_q    <= out_imm_d;
         out_mode_q   <= out_mode_d;
         out_pc_q     <= out_pc_d;
         skid_valid_q <= skid_valid_d;
         skid_imm_q   <= skid_imm_d;
         skid_mode_q  <= skid_mode_d;
         skid_pc_q    <= skid_pc_d;
      end
   end

   assign ex_valid = out_valid_q;
   assign ex_imm   = out_imm_q;
   assign ex_mode  = out_mode_q;
   assign ex_pc    = out_pc_q;

endmodule
